alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//   Parametrised, handshaked execute unit for the core0 pipeline. Replaces the
//   3-bit combinational ALU: adds XOR, SLT/SLTU and shifts, plus an iterative
//   shift-add multiplier (MUL, optional MULH/MULHU). Results are registered
//   with a zero flag and held under backpressure.
//   Sits between decode/regfile read and writeback.
// PARAMETERS
//   XLEN  32  operand/result width; >=8; power of two
//   SHW   $clog2(XLEN)  shift-amount width (derived, not overridden)
// PORTS
//   clk        in   1     clock, rising edge
//   rst        in   1     asynchronous, active-high reset
//   flush      in   1     synchronous abort of in-flight op and pending result
//   in_valid   in   1     operands/alu_ctrl valid
//   in_ready   out  1     unit can accept an op this cycle
//   alu_ctrl   in   4     operation select (encoding below)
//   src1       in   XLEN  operand A
//   src2       in   XLEN  operand B; shifts use src2[SHW-1:0]
//   out_valid  out  1     alu_res/zero valid
//   out_ready  in   1     consumer accepts result this cycle
//   alu_res    out  XLEN  result
//   zero       out  1     alu_res == 0
// BEHAVIOUR
//   - Ops: 0000 add, 0001 sub (src1+~src2+1), 0010 and, 0011 or, 0100 xor,
//     0101 slt (signed, result 0/1), 0110 sltu, 0111 sll, 1000 srl, 1001 sra,
//     1010 mul (low XLEN of product), 1011 mulh (signed x signed, high XLEN),
//     1100 mulhu (unsigned, high XLEN). Other codes: result 0, zero=1, 1-cycle.
//   - Arithmetic modulo 2^XLEN; no overflow/carry outputs.
//   - Reset: state=IDLE, out_valid=0, alu_res=0, zero=1, counter=0, acc=0.
//   - FSM IDLE/BUSY. in_ready = (state==IDLE) && (!out_valid || out_ready).
//   - Accept = in_valid && in_ready. Non-mul op: alu_res/zero registered at
//     the accept edge, out_valid=1 next cycle (latency 1); state stays IDLE.
//     Back-to-back ops at 1/cycle when out_ready held high.
//   - Mul op: latch |src1|,|src2| (signed only for mulh), result sign, clear
//     2*XLEN accumulator, count=0, go BUSY. One multiplier bit per cycle;
//     after XLEN iterations load alu_res (negate 2*XLEN product if sign), set
//     out_valid, return IDLE. out_valid rises XLEN+1 cycles after accept.
//   - out_valid stays 1 and alu_res/zero stable until out_valid && out_ready.
//     Result dropped with no new accept -> out_valid=0 next cycle.
//   - Result drop and new accept in same cycle: new result replaces it, no bubble.
//   - in_ready=0 throughout BUSY; in_valid ignored, no queuing.
//   - flush: next edge out_valid=0, state=IDLE, counter cleared; overrides a
//     simultaneous accept (op discarded). alu_res/zero keep last value.
//   - rst asserted mid-operation: immediate return to reset values.
//   - Changes on src1/src2/alu_ctrl after accept do not affect a BUSY op.
// CONFIGURATION
//   ALU_MULH_EN defined: 1011/1100 execute as above (2*XLEN accumulator).
//   Undefined: 1011/1100 are unknown codes (result 0, zero=1, 1-cycle);
//     accumulator is XLEN bits, mul still iterative.
// TESTING (XLEN=32, ALU_MULH_EN defined unless noted)
//   1 sub 5-7, out_ready=1 -> next cycle alu_res=0xFFFFFFFE, zero=0; sub 7-7
//     back-to-back -> alu_res=0, zero=1; in_ready held 1.
//   2 slt 0xFFFFFFFF,1 -> 1; sltu same -> 0; sra 0x80000000 by src2=0x24 -> 0xF8000000.
//   3 mul 0xFFFFFFFF*2 -> 0xFFFFFFFE, out_valid exactly 33 cycles after
//     accept, in_ready=0 during BUSY; mulh -1*-1 -> 0; mulhu 0xFFFFFFFF^2
//     -> 0xFFFFFFFE; mulh 0x80000000*2 -> 0xFFFFFFFF.
//   4 add result with out_ready=0 for 5 cycles -> out_valid and alu_res
//     stable, in_ready=0; release -> accepted, new op taken same cycle.
//   5 flush at cycle 10 of a mul -> out_valid never rises, in_ready=1 next
//     cycle; rst mid-mul -> all outputs at reset values, then add 1+1 -> 2.
//   6 ALU_MULH_EN undefined: code 1011 with 3,4 -> alu_res=0, zero=1, latency 1.

Source files
------------

// File: rtl/alu_if.sv
// Operand/result handshake bundle for the alu_seq execute unit.
// The master drives operands and result-ready; the slave is the ALU.
interface alu_if #(
    parameter int XLEN = 32
);
    // Both channels transfer on a clock edge where valid && ready. A producer
    // holds valid and its payload steady until that edge, and never waits on
    // ready before raising valid.
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_res;
    logic            zero;

    modport master (
        output in_valid, alu_ctrl, src1, src2, out_ready,
        input  in_ready, out_valid, alu_res, zero
    );

    modport slave (
        input  in_valid, alu_ctrl, src1, src2, out_ready,
        output in_ready, out_valid, alu_res, zero
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked execute unit: single-cycle logic/shift/compare ops plus an iterative
// shift-add multiplier. Define ALU_MULH_EN to enable MULH/MULHU (2*XLEN accumulator).
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush,
    alu_if.slave    bus,
    output logic    dbg_busy
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW:0] CNT_DONE = (SHW+1)'(XLEN);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    logic op_mul, op_mulh, op_mulhu, dec_mul;

`ifdef ALU_MULH_EN
    localparam int AW = 2 * XLEN;
    assign op_mulh  = (bus.alu_ctrl == 4'b1011);
    assign op_mulhu = (bus.alu_ctrl == 4'b1100);
`else
    localparam int AW = XLEN;
    assign op_mulh  = 1'b0;
    assign op_mulhu = 1'b0;
`endif

    assign op_mul  = (bus.alu_ctrl == 4'b1010);
    assign dec_mul = op_mul | op_mulh | op_mulhu;

    state_t          state_q, state_d;
    logic            out_valid_q;
    logic [XLEN-1:0] res_q;
    logic            zero_q;
    logic [AW-1:0]   acc, mcand;
    logic [XLEN-1:0] mplier;
    logic [SHW:0]    cnt;
    logic            neg_q, hi_q;

    logic            in_ready;
    logic            accept;
    logic [XLEN-1:0] comb_res;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [AW-1:0]   prod;
    logic [XLEN-1:0] mul_res;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign shamt    = bus.src2[SHW-1:0];

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_res   = res_q;
    assign bus.zero      = zero_q;
    assign dbg_busy      = (state_q == BUSY);

    always_comb begin
        comb_res = '0;
        case (bus.alu_ctrl)
            4'b0000: comb_res = bus.src1 + bus.src2;
            4'b0001: comb_res = bus.src1 + ~bus.src2 + XLEN'(1);
            4'b0010: comb_res = bus.src1 & bus.src2;
            4'b0011: comb_res = bus.src1 | bus.src2;
            4'b0100: comb_res = bus.src1 ^ bus.src2;
            4'b0101: comb_res = XLEN'($signed(bus.src1) < $signed(bus.src2));
            4'b0110: comb_res = XLEN'(bus.src1 < bus.src2);
            4'b0111: comb_res = bus.src1 << shamt;
            4'b1000: comb_res = bus.src1 >> shamt;
            4'b1001: comb_res = $signed(bus.src1) >>> shamt;
            default: comb_res = '0;
        endcase
    end

    // Only MULH treats operands as signed; magnitudes are multiplied and the sign reapplied.
    assign abs_a   = (op_mulh && bus.src1[XLEN-1]) ? -bus.src1 : bus.src1;
    assign abs_b   = (op_mulh && bus.src2[XLEN-1]) ? -bus.src2 : bus.src2;
    assign prod    = neg_q ? -acc : acc;
    assign mul_res = hi_q ? prod[AW-1 -: XLEN] : prod[XLEN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept && dec_mul) state_d = BUSY;
                BUSY:    if (cnt == CNT_DONE)   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b1;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            hi_q        <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            cnt         <= '0;
        end else if (accept && !dec_mul) begin
            res_q       <= comb_res;
            zero_q      <= (comb_res == '0);
            out_valid_q <= 1'b1;
        end else if (accept) begin
            acc         <= '0;
            mcand       <= AW'(abs_a);
            mplier      <= abs_b;
            cnt         <= '0;
            neg_q       <= op_mulh && (bus.src1[XLEN-1] ^ bus.src2[XLEN-1]);
            hi_q        <= op_mulh || op_mulhu;
            out_valid_q <= 1'b0;
        end else if (state_q == BUSY) begin
            // XLEN add/shift steps, then one extra edge to sign-correct and publish.
            if (cnt != CNT_DONE) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end else begin
                res_q       <= mul_res;
                zero_q      <= (mul_res == '0);
                out_valid_q <= 1'b1;
                cnt         <= '0;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule
